// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the ID/EX pipeline and the multiply/divide unit.
// Signal prefixes are from the unit's point of view (i_ into it, o_ out of it).
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cancel;
  logic             i_rd_hilo;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic             o_busy;
  logic             o_done;
  logic             o_stall;

  modport master (
    output i_start, i_op, i_a, i_b, i_cancel, i_rd_hilo,
    input  o_hi, o_lo, o_busy, o_done, o_stall
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_cancel, i_rd_hilo,
    output o_hi, o_lo, o_busy, o_done, o_stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Define FAST_MUL_EN to replace the iterative MULT/MULTU path by a one-cycle multiplier.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W2-1:0]    r_acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] r_opb;      // |multiplicand| or |divisor|
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_is_div_op;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic [W2-1:0]    w_mag;
  logic [W2-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_is_div_op = (bus.i_op == OP_DIV) || (bus.i_op == OP_DIVU);
  assign w_sa        = ((bus.i_op == OP_MULT) || (bus.i_op == OP_DIV)) && bus.i_a[WIDTH-1];
  assign w_sb        = ((bus.i_op == OP_MULT) || (bus.i_op == OP_DIV)) && bus.i_b[WIDTH-1];
  assign w_abs_a     = w_sa ? -bus.i_a : bus.i_a;
  assign w_abs_b     = w_sb ? -bus.i_b : bus.i_b;

  assign w_mul_sum   = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, r_opb};
  assign w_div_shift = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};

`ifdef FAST_MUL_EN
  logic [W2-1:0] w_prod;
  assign w_prod = W2'(r_acc[WIDTH-1:0]) * W2'(r_opb);
  assign w_mag  = r_is_div ? r_acc : w_prod;
`else
  assign w_mag  = r_acc;
`endif

  // Sign correction applied in FIX: product/quotient by sign XOR, remainder by dividend sign.
  assign w_prod_fix = r_neg_q ? -w_mag : w_mag;
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.i_start && !bus.i_cancel) begin
            case (bus.i_op)
              OP_MTHI: r_hi <= bus.i_a;
              OP_MTLO: r_lo <= bus.i_a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_is_div <= w_is_div_op;
                r_neg_q  <= w_sa ^ w_sb;
                r_neg_r  <= w_sa;
                r_opb    <= w_is_div_op ? w_abs_b : w_abs_a;
                r_acc    <= {WIDTH'(0), (w_is_div_op ? w_abs_a : w_abs_b)};
                r_cnt    <= CNT_W'(WIDTH);
                r_busy   <= 1'b1;
`ifdef FAST_MUL_EN
                r_state  <= w_is_div_op ? S_RUN : S_FIX;
`else
                r_state  <= S_RUN;
`endif
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (bus.i_cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_is_div) begin
              if (!w_div_diff[WIDTH]) r_acc <= {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
              else                    r_acc <= {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end else begin
              if (r_acc[0]) r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
              else          r_acc <= {1'b0, r_acc[W2-1:1]};
            end
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!bus.i_cancel) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[W2-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_hi    = r_hi;
  assign bus.o_lo    = r_lo;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_stall = r_busy & (bus.i_rd_hilo | bus.i_start);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) using an expected-result queue.
// Timing expectations follow FAST_MUL_EN when the bench is built with it defined.
module tb_muldiv_unit;

  localparam int unsigned WIDTH = 32;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = WIDTH + 2;
`endif
  localparam int DIV_LAT = WIDTH + 2;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  exp_t sb_q[$];

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference results from native integer arithmetic plus the divide-by-zero rules.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else begin
          q = sa / sb; r = sa % sb;
          e.lo = 32'(q); e.hi = 32'(r);
        end
      end
      3'd3: begin
        if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic int op_lat(input logic [2:0] op);
    return (op < 3'd2) ? MUL_LAT : DIV_LAT;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // Returns the cycle index (issue edge = 0) where done is seen, and busy cycles before it.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (bus.o_done !== 1'b1 && lat < 200) begin
      if (bus.o_busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    n_checks++; if (bus.o_hi !== 32'd0) $display("FAIL reset_hi got=%h exp=0", bus.o_hi); else n_pass++;
    n_checks++; if (bus.o_lo !== 32'd0) $display("FAIL reset_lo got=%h exp=0", bus.o_lo); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.o_done); else n_pass++;
    n_checks++; if (bus.o_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.o_stall); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int   lat, busy_n;
    exp_t e;
    sb_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB});
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, busy_n);
    n_checks++; if (lat != MUL_LAT) $display("FAIL mult_latency got=%0d exp=%0d", lat, MUL_LAT); else n_pass++;
    n_checks++; if (busy_n != MUL_LAT - 1) $display("FAIL mult_busy_cycles got=%0d exp=%0d", busy_n, MUL_LAT - 1); else n_pass++;
    e = sb_q.pop_front();
    n_checks++; if (bus.o_hi !== e.hi) $display("FAIL mult_hi got=%h exp=%h", bus.o_hi, e.hi); else n_pass++;
    n_checks++; if (bus.o_lo !== e.lo) $display("FAIL mult_lo got=%h exp=%h", bus.o_lo, e.lo); else n_pass++;
    @(negedge clk);
    sb_q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001});
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, busy_n);
    e = sb_q.pop_front();
    n_checks++; if (lat != MUL_LAT) $display("FAIL multu_latency got=%0d exp=%0d", lat, MUL_LAT); else n_pass++;
    n_checks++; if (bus.o_hi !== e.hi) $display("FAIL multu_hi got=%h exp=%h", bus.o_hi, e.hi); else n_pass++;
    n_checks++; if (bus.o_lo !== e.lo) $display("FAIL multu_lo got=%h exp=%h", bus.o_lo, e.lo); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_div;
    logic [2:0]  ops [3] = '{3'd2, 3'd3, 3'd2};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ehi [3] = '{32'hFFFF_FFFF, 32'd100, 32'd0};
    logic [31:0] elo [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int   lat, busy_n;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{hi: ehi[i], lo: elo[i]});
      issue(ops[i], as[i], bs[i]);
      wait_done(lat, busy_n);
      e = sb_q.pop_front();
      n_checks++; if (lat != DIV_LAT) $display("FAIL div%0d_latency got=%0d exp=%0d", i, lat, DIV_LAT); else n_pass++;
      n_checks++; if (bus.o_hi !== e.hi) $display("FAIL div%0d_hi got=%h exp=%h", i, bus.o_hi, e.hi); else n_pass++;
      n_checks++; if (bus.o_lo !== e.lo) $display("FAIL div%0d_lo got=%h exp=%h", i, bus.o_lo, e.lo); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int          lat, busy_n;
    logic [2:0]  op;
    logic [31:0] a, b;
    exp_t        e;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      case (i % 4)
        2: b = $urandom_range(1, 9);
        3: b = 32'd0;
        default: b = $urandom;
      endcase
      sb_q.push_back(model(op, a, b));
      issue(op, a, b);
      wait_done(lat, busy_n);
      e = sb_q.pop_front();
      n_checks++; if (lat != op_lat(op)) $display("FAIL rand%0d_latency op=%0d got=%0d exp=%0d", i, op, lat, op_lat(op)); else n_pass++;
      n_checks++;
      if ({bus.o_hi, bus.o_lo} !== e)
        $display("FAIL rand%0d op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, bus.o_hi, bus.o_lo, e.hi, e.lo);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_cancel;
    int n_done;
    issue(3'd4, 32'h1234, 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    issue(3'd3, 32'd50, 32'd7);
    repeat (9) @(negedge clk);
    n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL cancel_busy_before got=%b exp=1", bus.o_busy); else n_pass++;
    bus.i_cancel = 1'b1;
    @(negedge clk);
    bus.i_cancel = 1'b0;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL cancel_busy_after got=%b exp=0", bus.o_busy); else n_pass++;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done === 1'b1) n_done++;
      @(negedge clk);
    end
    n_checks++; if (n_done != 0) $display("FAIL cancel_no_done got=%0d exp=0", n_done); else n_pass++;
    n_checks++; if (bus.o_hi !== 32'h1234) $display("FAIL cancel_hi got=%h exp=00001234", bus.o_hi); else n_pass++;
    n_checks++; if (bus.o_lo !== 32'h5678) $display("FAIL cancel_lo got=%h exp=00005678", bus.o_lo); else n_pass++;
    bus.i_cancel = 1'b1;
    issue(3'd3, 32'd9, 32'd3);
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL cancel_start_div got=%b exp=0", bus.o_busy); else n_pass++;
    issue(3'd4, 32'hBEEF, 32'd0);
    bus.i_cancel = 1'b0;
    n_checks++; if (bus.o_hi !== 32'h1234) $display("FAIL cancel_start_mthi got=%h exp=00001234", bus.o_hi); else n_pass++;
  endtask

  task automatic test_stall;
    int   lat, n_bad;
    exp_t e;
    bus.i_rd_hilo = 1'b1;
    n_checks++; if (bus.o_stall !== 1'b0) $display("FAIL stall_idle got=%b exp=0", bus.o_stall); else n_pass++;
    sb_q.push_back(model(3'd3, 32'd1000, 32'd33));
    issue(3'd3, 32'd1000, 32'd33);
    lat   = 1;
    n_bad = 0;
    while (bus.o_done !== 1'b1 && lat < 200) begin
      if (bus.o_busy === 1'b1 && bus.o_stall !== 1'b1) n_bad++;
      bus.i_start = (lat == 5);
      bus.i_op    = 3'd5;
      bus.i_a     = 32'hAAAA;
      @(negedge clk);
      lat++;
    end
    bus.i_start = 1'b0;
    n_checks++; if (lat != DIV_LAT) $display("FAIL stall_latency got=%0d exp=%0d", lat, DIV_LAT); else n_pass++;
    n_checks++; if (n_bad != 0) $display("FAIL stall_busy_cycles missing=%0d exp=0", n_bad); else n_pass++;
    e = sb_q.pop_front();
    n_checks++; if (bus.o_lo !== e.lo) $display("FAIL stall_start_ignored_lo got=%h exp=%h", bus.o_lo, e.lo); else n_pass++;
    n_checks++; if (bus.o_stall !== 1'b0) $display("FAIL stall_after_done got=%b exp=0", bus.o_stall); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.o_stall !== 1'b0) $display("FAIL stall_idle_after got=%b exp=0", bus.o_stall); else n_pass++;
    bus.i_rd_hilo = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int n_done;
    issue(3'd4, 32'hCAFE, 32'd0);
    issue(3'd0, 32'd12345, 32'd678);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_hi !== 32'd0) $display("FAIL rstmid_hi got=%h exp=0", bus.o_hi); else n_pass++;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done === 1'b1) n_done++;
      @(negedge clk);
    end
    n_checks++; if (n_done != 0) $display("FAIL rstmid_no_done got=%0d exp=0", n_done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int   lat, busy_n;
    exp_t e;
    sb_q.push_back(model(3'd0, 32'd6, 32'd7));
    issue(3'd0, 32'd6, 32'd7);
    wait_done(lat, busy_n);
    e = sb_q.pop_front();
    n_checks++; if (lat != MUL_LAT) $display("FAIL b2b_latency got=%0d exp=%0d", lat, MUL_LAT); else n_pass++;
    n_checks++; if (busy_n != MUL_LAT - 1) $display("FAIL b2b_busy_cycles got=%0d exp=%0d", busy_n, MUL_LAT - 1); else n_pass++;
    n_checks++; if (bus.o_lo !== e.lo || bus.o_lo !== 32'd42) $display("FAIL b2b_lo got=%h exp=0000002a", bus.o_lo); else n_pass++;
    n_checks++; if (bus.o_hi !== 32'd0) $display("FAIL b2b_hi got=%h exp=0", bus.o_hi); else n_pass++;
    @(negedge clk);
    issue(3'd5, 32'd9, 32'd0);
    n_checks++; if (bus.o_lo !== 32'd9) $display("FAIL b2b_mtlo got=%h exp=00000009", bus.o_lo); else n_pass++;
    n_checks++; if (bus.o_done !== 1'b0) $display("FAIL b2b_mtlo_done got=%b exp=0", bus.o_done); else n_pass++;
    n_checks++; if (sb_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); else n_pass++;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_op      = 3'd0;
    bus.i_a       = '0;
    bus.i_b       = '0;
    bus.i_cancel  = 1'b0;
    bus.i_rd_hilo = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_mult;
    test_div;
    test_random;
    test_cancel;
    test_stall;
    test_reset_mid_op;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

endmodule
